// File: rtl/s38417_pkg.sv
// Shared types and constants for the s38417 codeword transmitter.
// Latency: n/a (declarations only). Backpressure: n/a.
package s38417_pkg;

    localparam int WIDTH    = 8;
    localparam int NBANK    = 3;
    localparam int REPEAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] BANK0 = 2'd0;
    localparam logic [1:0] BANK1 = 2'd1;
    localparam logic [1:0] BANK2 = 2'd2;

    localparam logic [NBANK-1:0] SEL_B0 = 3'b001;
    localparam logic [NBANK-1:0] SEL_B1 = 3'b010;
    localparam logic [NBANK-1:0] SEL_B2 = 3'b100;

    function automatic logic [NBANK-1:0] bank_sel(input logic [1:0] idx);
        logic [NBANK-1:0] sel;
        case (idx)
            BANK0:   sel = SEL_B0;
            BANK1:   sel = SEL_B1;
            BANK2:   sel = SEL_B2;
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/s38417_bank_rf.sv
// Three live codeword banks with one write port plus a snapshot copy read by index.
// Latency: write/snapshot visible next cycle, snapshot read combinational. Backpressure: none.
module s38417_bank_rf
    import s38417_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         CK,
    input  logic         RST,
    input  logic         i_wr_en,
    input  logic [1:0]   i_wr_bank,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_snap,
    input  logic [1:0]   i_rd_idx,
    output logic [W-1:0] o_rd_word
);

    logic [W-1:0] r_bank [NBANK];
    logic [W-1:0] r_snap [NBANK];

    // Snapshot copies pre-edge bank contents, so a same-cycle write is not captured.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NBANK; i++) begin
                r_bank[i] <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBANK; i++) begin
                if (i_wr_en && (i_wr_bank == 2'(i))) begin
                    r_bank[i] <= i_wr_data;
                end
                if (i_snap) begin
                    r_snap[i] <= r_bank[i];
                end
            end
        end
    end

    always_comb begin
        o_rd_word = '0;
        case (i_rd_idx)
            BANK0:   o_rd_word = r_snap[0];
            BANK1:   o_rd_word = r_snap[1];
            BANK2:   o_rd_word = r_snap[2];
            default: o_rd_word = '0;
        endcase
    end

endmodule

// File: rtl/s38417_codeword_tx.sv
// Sequences snapshotted banks 0->1->2 for N passes to the s38417 checker; S38417_CODEWORD_PARITY_EN adds tx_par.
// Latency: first beat the cycle after start, then 1 beat/cycle; done the cycle after the last accept.
// Backpressure: beat holds (valid, select, word stable) until tx_ready & gate_en on a clock edge.
module s38417_codeword_tx
    import s38417_pkg::*;
#(
    parameter int WIDTH    = s38417_pkg::WIDTH,
    parameter int NBANK    = s38417_pkg::NBANK,
    parameter int REPEAT_W = s38417_pkg::REPEAT_W
) (
    input  logic                CK,
    input  logic                RST,
    input  logic                wr_en,
    input  logic [1:0]          wr_bank,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                start,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    input  logic                gate_en,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [NBANK-1:0]    tx_sel,
    output logic [WIDTH-1:0]    tx_word,
    output logic                tx_last,
    output logic                tx_par,
    output logic                busy,
    output logic                done
);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_idx;
    logic [REPEAT_W-1:0] r_pass;
    logic                w_accept;
    logic                w_last_beat;
    logic                w_snap;
    logic [WIDTH-1:0]    w_rd_word;

    assign w_accept    = (r_state == SEND) && tx_ready && gate_en;
    assign w_last_beat = (r_idx == BANK2) && (r_pass == REPEAT_W'(1));
    assign w_snap      = (r_state == IDLE) && start;

    s38417_bank_rf #(.W(WIDTH)) u_bank_rf (
        .CK        (CK),
        .RST       (RST),
        .i_wr_en   (wr_en),
        .i_wr_bank (wr_bank),
        .i_wr_data (wr_data),
        .i_snap    (w_snap),
        .i_rd_idx  (r_idx),
        .o_rd_word (w_rd_word)
    );

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_idx   <= BANK0;
            r_pass  <= '0;
        end else begin
            r_state <= w_next;
            if (w_snap) begin
                r_idx  <= BANK0;
                r_pass <= repeat_cnt;
            end else if (w_accept) begin
                if (r_idx == BANK2) begin
                    r_idx  <= BANK0;
                    r_pass <= r_pass - REPEAT_W'(1);
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (repeat_cnt != '0) ? SEND : DONE;
            SEND:    if (w_accept && w_last_beat) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (r_state == SEND);
        tx_sel   = tx_valid ? bank_sel(r_idx) : '0;
        tx_word  = tx_valid ? w_rd_word : '0;
        tx_last  = tx_valid && w_last_beat;
        busy     = (r_state == SEND);
        done     = (r_state == DONE);
`ifdef S38417_CODEWORD_PARITY_EN
        tx_par   = tx_valid && (^w_rd_word);
`else
        tx_par   = 1'b0;
`endif
    end

endmodule
